// File: rtl/seq_wide_compare_pkg.sv
// Shared definitions for the sequential wide comparator: FSM encoding and slice width.
package seq_wide_compare_pkg;

    localparam int CHUNK = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_wide_compare_cmp3_slice.sv
// Combinational unsigned compare of one CHUNK-bit slice; outputs are one-hot.
module cmp3_slice
    import seq_wide_compare_pkg::*;
(
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/seq_wide_compare.sv
// Multi-cycle unsigned magnitude comparator: one shared slice compare scans the
// zero-padded operands MSB chunk first, with valid/ready on both sides.
module seq_wide_compare
    import seq_wide_compare_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter bit EARLY_EXIT = 1'b1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t            r_state;
    logic [PADW-1:0]   r_a;
    logic [PADW-1:0]   r_b;
    logic [IDXW-1:0]   r_idx;
    logic              r_decided;
    logic              r_dec_gt;
    logic              r_out_valid;
    logic              r_gt;
    logic              r_eq;
    logic              r_lt;

    logic [CHUNK-1:0]  w_ca;
    logic [CHUNK-1:0]  w_cb;
    logic              w_gt;
    logic              w_eq;
    logic              w_lt;
    logic              w_fin;

    assign w_ca = CHUNK'(r_a >> (r_idx * CHUNK));
    assign w_cb = CHUNK'(r_b >> (r_idx * CHUNK));

    cmp3_slice u_slice (
        .i_a  (w_ca),
        .i_b  (w_cb),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    // Last chunk always ends the scan; early exit also ends it on the first difference.
    assign w_fin = (r_idx == '0) || (EARLY_EXIT && !w_eq);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_decided   <= 1'b0;
            r_dec_gt    <= 1'b0;
            r_out_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a       <= PADW'(a);
                        r_b       <= PADW'(b);
                        r_idx     <= IDXW'(NCHUNK - 1);
                        r_decided <= 1'b0;
                        r_dec_gt  <= 1'b0;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!r_decided && !w_eq) begin
                        r_decided <= 1'b1;
                        r_dec_gt  <= w_gt;
                    end
                    // A decision from a more significant chunk is never overridden.
                    if (w_fin) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_gt        <= r_decided ? r_dec_gt  : w_gt;
                        r_lt        <= r_decided ? !r_dec_gt : w_lt;
                        r_eq        <= !r_decided && w_eq;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_gt        <= 1'b0;
                        r_eq        <= 1'b0;
                        r_lt        <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;

endmodule

// File: tb/tb_seq_wide_compare.sv
// Scoreboard bench for seq_wide_compare: three configurations (12b early-exit,
// 12b full scan, 8b early-exit) driven one at a time and checked against a model.
module tb_seq_wide_compare;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   lat;
        int   acc;
    } exp_t;

    localparam int NI = 3;
    localparam int IW [NI] = '{12, 12, 8};
    localparam bit IE [NI] = '{1'b1, 1'b0, 1'b1};

    logic        clk;
    logic        rst;
    logic        vld  [NI];
    logic        rdy  [NI];
    logic        ov   [NI];
    logic        ordy [NI];
    logic        fgt  [NI];
    logic        feq  [NI];
    logic        flt  [NI];
    logic        bsy  [NI];
    logic [11:0] a_s  [NI];
    logic [11:0] b_s  [NI];

    exp_t        q    [NI][$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    seq_wide_compare #(.WIDTH(12), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
        .a(a_s[0]), .b(b_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .gt(fgt[0]), .eq(feq[0]), .lt(flt[0]), .busy(bsy[0]));

    seq_wide_compare #(.WIDTH(12), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
        .a(a_s[1]), .b(b_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .gt(fgt[1]), .eq(feq[1]), .lt(flt[1]), .busy(bsy[1]));

    seq_wide_compare #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .gt(fgt[2]), .eq(feq[2]), .lt(flt[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (cycle %0d)", nm, inst, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input logic g, input logic e, input logic l, input int lat);
        exp_t r;
        r.gt = g; r.eq = e; r.lt = l; r.lat = lat; r.acc = 0;
        return r;
    endfunction

    // Reference: plain integer compare; chunks examined follow from the highest differing bit.
    function automatic exp_t model(input int w, input bit ee, input logic [11:0] aa, input logic [11:0] bb);
        exp_t r;
        int nch, av, bv, x, hi, k;
        nch = (w + 2) / 3;
        av  = int'(aa) & ((1 << w) - 1);
        bv  = int'(bb) & ((1 << w) - 1);
        r.gt = (av > bv); r.eq = (av == bv); r.lt = (av < bv);
        k = nch;
        if (ee && av != bv) begin
            x  = av ^ bv;
            hi = 0;
            for (int p = 0; p < w; p++) if (x[p]) hi = p;
            k = nch - hi / 3;
        end
        r.lat = k + 1;
        r.acc = 0;
        return r;
    endfunction

    task automatic drive(input int i, input logic [11:0] aa, input logic [11:0] bb, input exp_t e);
        int n;
        exp_t ent;
        n = 0;
        @(negedge clk);
        a_s[i] = aa; b_s[i] = bb; vld[i] = 1'b1;
        while (!rdy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[i]) begin
            chk("accept_timeout", i, 32'(rdy[i]), 32'd1);
            vld[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ent = e;
        ent.acc = cyc;
        q[i].push_back(ent);
        vld[i] = 1'b0;
    endtask

    // Monitor: result checks on each new out_valid, stability and idle-flag checks otherwise.
    logic       prev_ov [NI] = '{default: 1'b0};
    logic [2:0] held    [NI] = '{default: 3'b0};
    logic       prev_rst = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                q[i].delete();
                prev_ov[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (prev_rst)
                    chk("reset_state", i, {28'd0, rdy[i], ov[i], bsy[i], fgt[i] | feq[i] | flt[i]}, 32'b1000);
                if (ov[i] && !prev_ov[i]) begin
                    if (q[i].size() == 0) begin
                        chk("unexpected_out", i, 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk("result_gt_eq_lt_lat", i,
                            {21'd0, fgt[i], feq[i], flt[i], 8'(cyc - e.acc + 1)},
                            {21'd0, e.gt, e.eq, e.lt, 8'(e.lat)});
                    end
                    held[i] = {fgt[i], feq[i], flt[i]};
                end else if (ov[i]) begin
                    chk("hold_flags_inready", i, {28'd0, fgt[i], feq[i], flt[i], rdy[i]}, {28'd0, held[i], 1'b0});
                end else begin
                    chk("flags_idle_zero", i, {29'd0, fgt[i], feq[i], flt[i]}, 32'd0);
                end
                prev_ov[i] = ov[i];
            end
        end
        prev_rst = rst;
    end

    initial begin
        int n;
        logic [11:0] ra, rb;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vld[i] = 1'b0; ordy[i] = 1'b1; a_s[i] = '0; b_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        drive(0, 12'h800, 12'h7FF, mk(1, 0, 0, 2));
        drive(0, 12'hABC, 12'hABC, mk(0, 1, 0, 5));
        drive(1, 12'h123, 12'h124, mk(0, 0, 1, 5));
        drive(1, 12'h900, 12'h100, mk(1, 0, 0, 5));

        ordy[0] = 1'b0;
        drive(0, 12'h5A5, 12'h5A4, mk(1, 0, 0, 5));
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 0, 32'(ov[0]), 32'd1);
        a_s[0] = 12'h000; b_s[0] = 12'h000; vld[0] = 1'b1;
        repeat (6) @(negedge clk);
        vld[0] = 1'b0; ordy[0] = 1'b1;

        drive(0, 12'hABC, 12'hABC, mk(0, 1, 0, 5));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        drive(0, 12'h001, 12'h000, mk(1, 0, 0, 5));

        drive(2, 12'h0FF, 12'h0FE, mk(1, 0, 0, 4));
        drive(2, 12'h000, 12'h080, mk(0, 0, 1, 2));

        for (int t = 0; t < 1000; t++) begin
            ra = 12'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? ra : 12'($urandom_range(0, 255));
            drive(2, ra, rb, model(IW[2], IE[2], ra, rb));
            if ($urandom_range(0, 1) == 1) begin
                ordy[2] = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                ordy[2] = 1'b1;
            end
        end
        for (int t = 0; t < 400; t++) begin
            int i;
            i  = t % 2;
            ra = 12'($urandom_range(0, 4095));
            rb = ($urandom_range(0, 7) == 0) ? ra : 12'($urandom_range(0, 4095));
            drive(i, ra, rb, model(IW[i], IE[i], ra, rb));
        end

        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 0, 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
